mvm_result_collector: RTL and testbench

- Receive end of the matrix-vector multiplier output stream. Accepts the serialized result elements y[0..NROWS_A-1] one per handshake and reassembles them into whole result vectors.
- Buffers up to NUM_S complete vectors in a small vector FIFO.
- Presents each vector in parallel on a valid/ready output to the downstream consumer (activation stage or host readback).
- Decouples the multiplier's per-element output rate from the consumer's per-vector rate, with back-pressure both ways.

---
 rtl/mvm_result_collector.sv | 85 ++++++++
 tb/tb_mvm_result_collector.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_result_collector.sv
// rtl/mvm_result_collector.sv - reassembles serialized result elements into whole vectors and buffers them
module mvm_result_collector #(
    parameter int NROWS_A = 4,
    parameter int DATA_W  = 16,
    parameter int NUM_S   = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DATA_W-1:0]               s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    output logic [NROWS_A*DATA_W-1:0]       m_vec,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [$clog2(NUM_S+1)-1:0]      vec_count,
    output logic                            partial
);

    localparam int VEC_W = NROWS_A * DATA_W;
    localparam int PTR_W = (NUM_S > 1) ? $clog2(NUM_S) : 1;
    localparam int IDX_W = (NROWS_A > 1) ? $clog2(NROWS_A) : 1;
    localparam int CNT_W = $clog2(NUM_S + 1);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_S);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NROWS_A - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_S - 1);

    logic [VEC_W-1:0] slot_mem [NUM_S];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [IDX_W-1:0] elem_idx;
    logic [CNT_W-1:0] count;

    logic in_xfer;
    logic out_xfer;
    logic vec_done;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // s_ready depends only on stored occupancy and reset, never on m_ready
    assign s_ready   = ~reset & (count < FULL_CNT);
    assign m_valid   = (count != '0);
    assign m_vec     = slot_mem[rd_ptr];
    assign vec_count = count;
    assign partial   = (elem_idx != '0);

    assign in_xfer  = s_valid & s_ready;
    assign out_xfer = m_valid & m_ready;
    assign vec_done = in_xfer & (elem_idx == LAST_IDX);

    // Element storage: slot contents are not cleared on reset, pointers make stale data unreachable
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            slot_mem[wr_ptr][elem_idx*DATA_W +: DATA_W] <= s_data;
        end
    end

    // Pointer, element index and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            elem_idx <= '0;
            count    <= '0;
        end else begin
            if (in_xfer) begin
                elem_idx <= (elem_idx == LAST_IDX) ? '0 : elem_idx + 1'b1;
            end
            if (vec_done) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (out_xfer) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({vec_done, out_xfer})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_mvm_result_collector.sv
// tb/tb_mvm_result_collector.sv - self-checking bench for mvm_result_collector
module tb_mvm_result_collector;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int NS = 2;
    localparam int VW = NR * DW;
    localparam int CW = $clog2(NS + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [VW-1:0] m_vec;
    logic          m_valid;
    logic          m_ready;
    logic [CW-1:0] vec_count;
    logic          partial;

    mvm_result_collector #(.NROWS_A(NR), .DATA_W(DW), .NUM_S(NS)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_vec     (m_vec),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .vec_count (vec_count),
        .partial   (partial)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: queue of complete vectors plus the vector under assembly
    logic [VW-1:0] mq[$];
    logic [VW-1:0] mcur;
    int            midx;
    int            pops;

    // outputs observed in the most recent step
    logic          o_sr, o_mv, o_pa;
    logic [VW-1:0] o_vec;
    logic [CW-1:0] o_vc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] vec4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c, input logic [DW-1:0] d);
        return {d, c, b, a};
    endfunction

    // one clock: drive, sample at negedge against the model, advance the model at posedge
    task automatic step(input logic rst, input logic sv, input logic [DW-1:0] sd, input logic mr);
        logic exp_sr;
        logic exp_mv;
        reset   = rst;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        @(negedge clk);
        o_sr  = s_ready;
        o_mv  = m_valid;
        o_pa  = partial;
        o_vec = m_vec;
        o_vc  = vec_count;
        exp_sr = !rst && (mq.size() < NS);
        exp_mv = (mq.size() != 0);
        chk("s_ready", 64'(o_sr), 64'(exp_sr));
        chk("m_valid", 64'(o_mv), 64'(exp_mv));
        chk("vec_count", 64'(o_vc), 64'(mq.size()));
        chk("partial", 64'(o_pa), 64'(midx != 0));
        if (exp_mv) chk("m_vec", 64'(o_vec), 64'(mq[0]));
        @(posedge clk);
        if (rst) begin
            mq.delete();
            midx = 0;
        end else begin
            if (exp_mv && mr) begin
                void'(mq.pop_front());
                pops++;
            end
            if (sv && exp_sr) begin
                mcur[midx*DW +: DW] = sd;
                midx++;
                if (midx == NR) begin
                    mq.push_back(mcur);
                    midx = 0;
                end
            end
        end
        #1;
    endtask

    task automatic push_vec(input int base, input logic mr);
        for (int i = 0; i < NR; i++) step(1'b0, 1'b1, DW'(base + i), mr);
    endtask

    typedef struct {
        logic          rst;
        logic          sv;
        logic [DW-1:0] sd;
        logic          mr;
        logic          e_sr;
        logic          e_mv;
        logic [CW-1:0] e_vc;
        logic          e_pa;
        logic [VW-1:0] e_vec;
    } row_t;

    row_t tab[13];

    initial begin
        logic          prev_hold;
        logic [VW-1:0] prev_vec;
        int            cyc;

        tab[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, '0};
        tab[1]  = '{1'b0, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, '0};
        tab[2]  = '{1'b0, 1'b1, 16'h0002, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, '0};
        tab[3]  = '{1'b0, 1'b1, 16'h0003, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, '0};
        tab[4]  = '{1'b0, 1'b1, 16'h0004, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, '0};
        tab[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 64'h0004_0003_0002_0001};
        tab[6]  = '{1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, '0};
        tab[7]  = '{1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, '0};
        tab[8]  = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, '0};
        tab[9]  = '{1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, '0};
        tab[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 64'h7FFF_0000_8000_FFFF};
        tab[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 64'h7FFF_0000_8000_FFFF};
        tab[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, '0};

        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        mcur    = '0;
        midx    = 0;
        pops    = 0;
        repeat (2) @(posedge clk);
        #1;

        // basic stream and bit-exact extreme values
        for (int r = 0; r < 13; r++) begin
            step(tab[r].rst, tab[r].sv, tab[r].sd, tab[r].mr);
            chk($sformatf("tab%0d_s_ready", r), 64'(o_sr), 64'(tab[r].e_sr));
            chk($sformatf("tab%0d_m_valid", r), 64'(o_mv), 64'(tab[r].e_mv));
            chk($sformatf("tab%0d_vec_count", r), 64'(o_vc), 64'(tab[r].e_vc));
            chk($sformatf("tab%0d_partial", r), 64'(o_pa), 64'(tab[r].e_pa));
            if (tab[r].e_mv) chk($sformatf("tab%0d_m_vec", r), 64'(o_vec), 64'(tab[r].e_vec));
        end

        // fill to capacity, then drain in order
        step(1'b1, 1'b0, '0, 1'b0);
        push_vec(10, 1'b0);
        push_vec(20, 1'b0);
        step(1'b0, 1'b1, 16'd30, 1'b0);
        chk("t2_full_count", 64'(o_vc), 64'd2);
        chk("t2_full_s_ready", 64'(o_sr), 64'd0);
        step(1'b0, 1'b1, 16'd30, 1'b1);
        chk("t2_first_pop", 64'(o_vec), 64'(vec4(10, 11, 12, 13)));
        chk("t2_held_off", 64'(o_sr), 64'd0);
        step(1'b0, 1'b1, 16'd30, 1'b1);
        chk("t2_s_ready_after_pop", 64'(o_sr), 64'd1);
        chk("t2_second", 64'(o_vec), 64'(vec4(20, 21, 22, 23)));
        for (int i = 1; i < NR; i++) step(1'b0, 1'b1, DW'(30 + i), 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("t2_third_valid", 64'(o_mv), 64'd1);
        chk("t2_third", 64'(o_vec), 64'(vec4(30, 31, 32, 33)));

        // simultaneous completion and pop, across the pointer wrap
        step(1'b1, 1'b0, '0, 1'b0);
        push_vec(40, 1'b0);
        for (int i = 0; i < NR - 1; i++) step(1'b0, 1'b1, DW'(50 + i), 1'b0);
        step(1'b0, 1'b1, 16'd53, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("t3_count_kept", 64'(o_vc), 64'd1);
        chk("t3_newer_vec", 64'(o_vec), 64'(vec4(50, 51, 52, 53)));
        for (int i = 0; i < NR - 1; i++) step(1'b0, 1'b1, DW'(60 + i), 1'b0);
        step(1'b0, 1'b1, 16'd63, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("t3_wrap_count", 64'(o_vc), 64'd1);
        chk("t3_wrap_vec", 64'(o_vec), 64'(vec4(60, 61, 62, 63)));
        step(1'b0, 1'b0, '0, 1'b1);

        // reset with one vector pending and a partial one in progress
        step(1'b1, 1'b0, '0, 1'b0);
        push_vec(70, 1'b0);
        step(1'b0, 1'b1, 16'd80, 1'b0);
        step(1'b0, 1'b1, 16'd81, 1'b0);
        step(1'b1, 1'b1, 16'd82, 1'b0);
        chk("t5_s_ready_in_reset", 64'(o_sr), 64'd0);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("t5_m_valid", 64'(o_mv), 64'd0);
        chk("t5_vec_count", 64'(o_vc), 64'd0);
        chk("t5_partial", 64'(o_pa), 64'd0);
        chk("t5_s_ready_release", 64'(o_sr), 64'd1);
        push_vec(5, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("t5_post_reset_vec", 64'(o_vec), 64'(vec4(5, 6, 7, 8)));

        // gapped random input, random consumer stalls
        step(1'b1, 1'b0, '0, 1'b0);
        pops      = 0;
        prev_hold = 1'b0;
        prev_vec  = '0;
        cyc       = 0;
        while (pops < 50 && cyc < 3000) begin
            step(1'b0, 1'(cyc % 2 == 0), DW'($urandom), 1'($urandom_range(0, 1)));
            if (prev_hold) begin
                chk("t4_hold_valid", 64'(o_mv), 64'd1);
                chk("t4_hold_vec", 64'(o_vec), 64'(prev_vec));
            end
            prev_hold = o_mv & ~m_ready;
            prev_vec  = o_vec;
            cyc++;
        end
        chk("t4_vectors_popped", 64'(pops >= 50), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
